modulator_scheduler: RTL and testbench
======================================

Name: modulator_scheduler

Overview:
- Round-robin scheduler that shares one BPSK modulator among REQUESTERS word sources.
- Each requester offers a BITS-wide word on a valid/ready handshake. The block grants one requester, registers its word onto the modulator data bus, and issues a one-cycle start pulse.
- It times the frame itself, enforces an inter-frame guard gap, then re-arbitrates.
- Sits between the link-layer framers and the modulator in the transmitter.

Parameters:
- REQUESTERS, 4, number of requesters; must be 2 or more.
- BITS, 32, payload word width; must match the modulator.
- FRAME_CYCLES, (BITS+1)*WAVELENGTH+2, cycles from start pulse until the modulator is idle again.
- GUARD_CYCLES, 8, idle cycles between frames; 0 is legal.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  REQUESTERS  per-requester word offered
- req_data  in  REQUESTERS*BITS  packed words; requester i occupies [i*BITS +: BITS]
- req_ready  out  REQUESTERS  one-hot accept strobe
- mod_data  out  BITS  word held to the modulator
- mod_start  out  1  one-cycle start pulse; the modulator edge-detects it
- grant_id  out  $clog2(REQUESTERS)  index of the requester currently owning the modulator
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (reset low at a clk edge): state FLUSH, mod_start 0, mod_data 0, req_ready 0, grant_id 0, RR pointer 0, counter FRAME_CYCLES-1.
- FLUSH: count down to 0, then go to IDLE. This drains any frame still in flight in the modulator, which is not reset by this block. Applies at power-up and after a mid-frame reset.
- IDLE, no req_valid: stay in IDLE.
- IDLE, any req_valid:
  - Winner = first asserted requester at or after the RR pointer, wrapping modulo REQUESTERS.
  - In the same cycle, combinationally assert req_ready[winner] = 1. That cycle is the handshake.
  - Register mod_data <= req_data[winner] and grant_id <= winner.
  - Set pointer <= (winner+1) mod REQUESTERS. Go to START.
- req_ready is asserted only in IDLE, and only for the winner. Requesters must hold data stable while valid and unaccepted.
- START: mod_start = 1 for exactly one cycle. Load counter with FRAME_CYCLES-1. Go to TX.
- TX: count down; mod_data held stable. At 0, go to GUARD, or straight to IDLE when GUARD_CYCLES = 0.
- GUARD: count GUARD_CYCLES cycles, then go to IDLE.
- mod_start is low for at least FRAME_CYCLES cycles between pulses, so the modulator's edge detector always sees a fresh rising edge.
- Grant-to-start latency: 1 cycle (the handshake cycle, then START).
- Minimum frame period: 2 + FRAME_CYCLES + GUARD_CYCLES cycles.
- req_valid changes outside IDLE are ignored. A requester dropping valid mid-frame does not abort the frame.
- mod_data, grant_id and the pointer hold their values outside IDLE.
- Reset asserted in any state overrides everything, including START.

Optional Feature:
- Macro: MODSCHED_PREAMBLE_EN.
- Defined:
  - Each granted frame is preceded by a preamble frame. mod_data = PREAMBLE_WORD (package constant 32'hA5A5_5A5A, truncated or zero-extended to BITS).
  - The preamble frame runs the full START, TX and GUARD sequence.
  - The requester's word is kept in a shadow register, then sent by a second START, TX and GUARD pass.
  - Added states PRE_START and PRE_TX.
  - Handshake timing is unchanged: req_ready fires at grant.
  - busy stays high throughout both frames.
- Undefined: no preamble states and no shadow register; behaviour exactly as above.

Decomposition:
- Shared package modsched_pkg holds:
  - typedef enum of states FLUSH, IDLE, START, TX, GUARD, PRE_START, PRE_TX;
  - PREAMBLE_WORD;
  - a default-FRAME_CYCLES helper function using WAVELENGTH from core_params.
- One sub-module, rr_arbiter #(N): inputs req[N], ptr, en; outputs grant one-hot, grant_idx, any. Purely combinational, reused by other shared-resource blocks.

Test Plan:
- Power-up: hold reset low 3 cycles, release with req_valid=4'b0001 → busy=1, no req_ready for FRAME_CYCLES cycles; then req_ready[0] pulses and mod_data=req_data[0] on the next edge.
- Round-robin: all four valid continuously, words 32'h11111111..32'h44444444 → grants 0,1,2,3,0; mod_start pulse spacing = 2+FRAME_CYCLES+GUARD_CYCLES.
- Single requester: req_valid=4'b0100 held → repeated grants to 2; the pointer wraps 3→0→…→2 without skipping cycles.
- Data stability: change req_data[1] during TX after grant to 1 → mod_data unchanged until the next IDLE grant.
- Mid-frame reset: assert reset at TX cycle 10 → next edge gives state FLUSH, mod_start=0, mod_data=0; no new mod_start for FRAME_CYCLES cycles.
- GUARD_CYCLES=0 build: back-to-back requests → TX returns directly to IDLE; mod_start pulses exactly 2+FRAME_CYCLES apart.
- MODSCHED_PREAMBLE_EN build: one request of 32'hDEADBEEF → mod_data=32'hA5A55A5A for the first frame, 32'hDEADBEEF for the second; two mod_start pulses.

Source files
------------

// File: rtl/modsched_pkg.sv
// modsched_pkg: shared types and constants for the modulator scheduler.
//   state_e               scheduler FSM states (preamble states are used only
//                         when MODSCHED_PREAMBLE_EN is defined)
//   PREAMBLE_WORD         word sent ahead of each granted frame in preamble builds
//   WAVELENGTH            carrier cycles per bit; must track core_params
//   default_frame_cycles  start-pulse-to-idle time of the modulator for a word width
package modsched_pkg;

  localparam int WAVELENGTH = 4;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    START,
    TX,
    GUARD,
    PRE_START,
    PRE_TX
  } state_e;

  localparam logic [31:0] PREAMBLE_WORD = 32'hA5A5_5A5A;

  // One extra bit slot for the modulator's framing plus two cycles of
  // start-edge detection and return to idle.
  function automatic int default_frame_cycles(input int bits);
    return (bits + 1) * WAVELENGTH + 2;
  endfunction

endpackage

// File: rtl/modulator_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        per-requester request vector
//   ptr        highest-priority index this round
//   en         qualifies the whole pick; no grant when low
//   grant      one-hot grant (zero when nothing granted)
//   grant_idx  binary index of the granted requester
//   any        a grant is being made
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  logic [W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    // Walk from ptr upward, wrapping, and keep the first hit.
    for (int i = 0; i < N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (en && !any && req[idx]) begin
        any       = 1'b1;
        grant_idx = idx;
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/modulator_scheduler.sv
// modulator_scheduler: shares one BPSK modulator among REQUESTERS word sources.
// Grants round-robin on a valid/ready handshake, registers the winning word
// onto mod_data, pulses mod_start for one cycle, times the frame, enforces an
// inter-frame guard gap, then re-arbitrates.
//   clk        system clock
//   reset      synchronous active-low reset
//   req_valid  per-requester word offered
//   req_data   packed words, requester i at [i*BITS +: BITS]
//   req_ready  one-hot accept strobe (IDLE only, combinational)
//   mod_data   word held to the modulator
//   mod_start  one-cycle start pulse
//   grant_id   index of the requester owning the modulator
//   busy       high in every state except IDLE
// Build option: MODSCHED_PREAMBLE_EN sends PREAMBLE_WORD as a full frame ahead
// of every granted word; the granted word waits in a shadow register.
//
// state     | meaning
// FLUSH     | wait one frame time for a modulator frame that may still be in flight
// IDLE      | arbitrate; handshake and register the winner's word
// PRE_START | start pulse for the preamble frame
// PRE_TX    | preamble frame on air
// START     | start pulse for the granted word
// TX        | granted word on air
// GUARD     | inter-frame idle gap
module modulator_scheduler
  import modsched_pkg::*;
#(
  parameter int REQUESTERS   = 4,
  parameter int BITS         = 32,
  parameter int FRAME_CYCLES = default_frame_cycles(BITS),
  parameter int GUARD_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [REQUESTERS-1:0]         req_valid,
  input  logic [REQUESTERS*BITS-1:0]    req_data,
  output logic [REQUESTERS-1:0]         req_ready,
  output logic [BITS-1:0]               mod_data,
  output logic                          mod_start,
  output logic [$clog2(REQUESTERS)-1:0] grant_id,
  output logic                          busy
);

  localparam int IDW     = $clog2(REQUESTERS);
  localparam int CNT_MAX = (FRAME_CYCLES > GUARD_CYCLES) ? FRAME_CYCLES : GUARD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [BITS-1:0] mod_data_q, mod_data_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
`ifdef MODSCHED_PREAMBLE_EN
  logic [BITS-1:0] shadow_q, shadow_d;
  logic            pre_phase_q, pre_phase_d;  // GUARD currently follows the preamble
`endif

  logic                  arb_en;
  logic [REQUESTERS-1:0] arb_grant;
  logic [IDW-1:0]        arb_idx;
  logic                  arb_any;
  logic [BITS-1:0]       win_word;

  rr_arbiter #(.N(REQUESTERS), .W(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    win_word = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (arb_grant[i]) win_word = req_data[i*BITS +: BITS];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    mod_data_d = mod_data_q;
    grant_id_d = grant_id_q;
`ifdef MODSCHED_PREAMBLE_EN
    shadow_d    = shadow_q;
    pre_phase_d = pre_phase_q;
`endif
    arb_en    = (state_q == IDLE);
    req_ready = '0;
    mod_start = 1'b0;

    unique case (state_q)
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      IDLE: begin
        if (arb_any) begin
          req_ready  = arb_grant;
          grant_id_d = arb_idx;
          ptr_d      = (arb_idx == IDW'(REQUESTERS - 1)) ? '0 : arb_idx + 1'b1;
`ifdef MODSCHED_PREAMBLE_EN
          shadow_d    = win_word;
          mod_data_d  = BITS'(PREAMBLE_WORD);
          pre_phase_d = 1'b1;
          state_d     = PRE_START;
`else
          mod_data_d = win_word;
          state_d    = START;
`endif
        end
      end
`ifdef MODSCHED_PREAMBLE_EN
      PRE_START: begin
        mod_start = 1'b1;
        cnt_d     = CNT_FRAME;
        state_d   = PRE_TX;
      end
      PRE_TX: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GUARD_CYCLES == 0) begin
          mod_data_d  = shadow_q;
          pre_phase_d = 1'b0;
          state_d     = START;
        end else begin
          cnt_d   = CNT_GUARD;
          state_d = GUARD;
        end
      end
`endif
      START: begin
        mod_start = 1'b1;
        cnt_d     = CNT_FRAME;
        state_d   = TX;
      end
      TX: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GUARD_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_GUARD;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
`ifdef MODSCHED_PREAMBLE_EN
          if (pre_phase_q) begin
            mod_data_d  = shadow_q;
            pre_phase_d = 1'b0;
            state_d     = START;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: begin
        state_d = FLUSH;
        cnt_d   = CNT_FRAME;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FLUSH;
      cnt_q      <= CNT_FRAME;
      ptr_q      <= '0;
      mod_data_q <= '0;
      grant_id_q <= '0;
`ifdef MODSCHED_PREAMBLE_EN
      shadow_q    <= '0;
      pre_phase_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      mod_data_q <= mod_data_d;
      grant_id_q <= grant_id_d;
`ifdef MODSCHED_PREAMBLE_EN
      shadow_q    <= shadow_d;
      pre_phase_q <= pre_phase_d;
`endif
    end
  end

  assign mod_data = mod_data_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_modulator_scheduler.sv
// tb_modulator_scheduler: scoreboard bench for modulator_scheduler (default
// build). A second instance with GUARD_CYCLES=0 checks back-to-back spacing.
module tb_modulator_scheduler;

  localparam int N      = 4;
  localparam int B      = 32;
  localparam int G      = 8;
  localparam int F      = (B + 1) * modsched_pkg::WAVELENGTH + 2;
  localparam int PERIOD = 2 + F + G;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*B-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [B-1:0]   mod_data;
  logic           mod_start;
  logic [1:0]     grant_id;
  logic           busy;

  logic [N-1:0]   req_valid2 = 4'b1111;
  logic [N*B-1:0] req_data2  = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
  logic [N-1:0]   req_ready2;
  logic [B-1:0]   mod_data2;
  logic           mod_start2;
  logic [1:0]     grant_id2;
  logic           busy2;

  modulator_scheduler #(.REQUESTERS(N), .BITS(B), .FRAME_CYCLES(F), .GUARD_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .mod_data(mod_data), .mod_start(mod_start),
    .grant_id(grant_id), .busy(busy)
  );

  modulator_scheduler #(.REQUESTERS(N), .BITS(B), .FRAME_CYCLES(F), .GUARD_CYCLES(0)) dut_g0 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_data(req_data2),
    .req_ready(req_ready2), .mod_data(mod_data2), .mod_start(mod_start2),
    .grant_id(grant_id2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   cyc        = 0;
  int   hs_cyc     = -100;
  int   last_start = -1;
  int   n_starts   = 0;
  int   m_ptr      = 0;

  function automatic int rr_pick(input logic [3:0] v, input int p);
    int k;
    for (int i = 0; i < 4; i++) begin
      k = (p + i) % 4;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Monitor: handshakes push the expected grant, start pulses pop and compare.
  always @(negedge clk) begin
    exp_t e;
    int   w;
    cyc++;
    if (!reset) begin
      sb_q.delete();
      m_ptr      = 0;
      last_start = -1;
      hs_cyc     = -100;
    end else begin
      if (req_ready != '0) begin
        w = rr_pick(req_valid, m_ptr);
        if (w < 0) begin
          chk("ready_spurious", req_ready, 0);
        end else begin
          chk("ready_onehot", req_ready, 4'b0001 << w);
          e.id   = w[1:0];
          e.data = req_data[w*32 +: 32];
          sb_q.push_back(e);
          m_ptr  = (w + 1) % 4;
          hs_cyc = cyc;
        end
      end
      if (mod_start) begin
        chk("start_latency", cyc - hs_cyc, 1);
        if (sb_q.size() == 0) begin
          chk("sb_underflow", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          chk("mod_data", mod_data, e.data);
          chk("grant_id", grant_id, e.id);
        end
        if (last_start >= 0) chk("start_period", cyc - last_start, PERIOD);
        last_start = cyc;
        n_starts++;
      end
    end
  end

  task automatic wait_starts(input int k, input int budget);
    int target;
    int n;
    target = n_starts + k;
    n = 0;
    while (n_starts < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n_starts < target) chk("start_timeout", n_starts, target);
  endtask

  task automatic wait_start2(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mod_start2 && n < 2 * F);
    if (!mod_start2) chk("g0_timeout", mod_start2, 1);
  endtask

  initial begin
    int n;
    int bad;
    int s;
    logic [1:0] g_prev;
    logic [1:0] g_exp;

    reset     = 1'b0;
    req_valid = 4'b0001;
    req_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    // Power-up
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_start", mod_start, 0);
    chk("rst_data", mod_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_gid", grant_id, 0);
    reset = 1'b1;

    n = 0;
    bad = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 2 * F) begin
      if (!busy) bad++;
      n++;
      @(negedge clk);
    end
    chk("flush_len", n, F);
    chk("flush_busy", bad, 0);
    @(posedge clk);
    #1;
    chk("pwr_data", mod_data, 32'h1111_1111);
    chk("pwr_start", mod_start, 1);
    @(negedge clk);
    #1;

    // Round-robin, all requesters valid: grants 1,2,3,0,1
    req_valid = 4'b1111;
    wait_starts(5, 6 * PERIOD);
    chk("rr_last_gid", grant_id, 1);

    // Single requester: pointer must wrap back around to 2 every frame
    req_valid = 4'b0100;
    wait_starts(3, 4 * PERIOD);
    chk("single_gid", grant_id, 2);

    // Data stability while on air
    req_valid = 4'b0010;
    wait_starts(1, 2 * PERIOD);
    chk("stab_gid", grant_id, 1);
    chk("stab_data", mod_data, 32'h2222_2222);
    repeat (5) @(negedge clk);
    req_data[63:32] = 32'hCAFE_F00D;
    bad = 0;
    n = 0;
    #1;
    while (!mod_start && n < 2 * PERIOD) begin
      if (mod_data !== 32'h2222_2222) bad++;
      @(negedge clk);
      #1;
      n++;
    end
    chk("stab_hold", bad, 0);
    chk("stab_new", mod_data, 32'hCAFE_F00D);

    // Mid-frame reset at TX cycle 10
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mfr_busy", busy, 1);
    chk("mfr_start", mod_start, 0);
    chk("mfr_data", mod_data, 0);
    chk("mfr_gid", grant_id, 0);
    chk("mfr_ready", req_ready, 0);
    reset = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mod_start && n < 2 * F + 4);
    chk("mfr_gap", n, F + 2);

    // GUARD_CYCLES=0 instance: back-to-back frames, rotating grants
    wait_start2(s);
    g_prev = grant_id2;
    for (int i = 0; i < 3; i++) begin
      wait_start2(s);
      g_exp = g_prev + 2'd1;
      chk("g0_period", s, F + 2);
      chk("g0_gid", grant_id2, g_exp);
      chk("g0_data", mod_data2, req_data2[g_exp*32 +: 32]);
      g_prev = g_exp;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
